// File: rtl/gsim_pkg.sv
// ---------------------------------------------------------------------------
// gsim_pkg
// Shared definitions for the Gauss-Seidel solver datapath:
//   - gsim_state_e : FILL / RUN state of the circular vector register
//   - GSIM_BIT_WIDTH, GSIM_DEPTH, GSIM_NTAP : default solver dimensions
// ---------------------------------------------------------------------------
package gsim_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } gsim_state_e;

  localparam int GSIM_BIT_WIDTH = 32;
  localparam int GSIM_DEPTH     = 16;
  localparam int GSIM_NTAP      = 3;

endpackage

// File: rtl/gsim_rot_net.sv
// ---------------------------------------------------------------------------
// gsim_rot_net
// Combinational circular barrel rotator built from log2(DEPTH) mux stages.
// Output entry i takes input entry (i + rot_amt) mod DEPTH.
// Ports:
//   vec_in   in  DEPTH*BIT_WIDTH  entry i at bits [i*BIT_WIDTH +: BIT_WIDTH]
//   rot_amt  in  AW               rotate amount
//   vec_out  out DEPTH*BIT_WIDTH  rotated vector, same packing as vec_in
// ---------------------------------------------------------------------------
module gsim_rot_net
  import gsim_pkg::*;
#(
  parameter  int BIT_WIDTH = GSIM_BIT_WIDTH,
  parameter  int DEPTH     = GSIM_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic [DEPTH*BIT_WIDTH-1:0] vec_in,
  input  logic [AW-1:0]              rot_amt,
  output logic [DEPTH*BIT_WIDTH-1:0] vec_out
);

  logic [DEPTH*BIT_WIDTH-1:0] stg [AW+1];

  assign stg[0] = vec_in;

  // Stage s rotates by 2**s when rot_amt[s] is set.
  for (genvar s = 0; s < AW; s++) begin : g_stage
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      localparam int SRC = (i + (1 << s)) % DEPTH;
      assign stg[s+1][i*BIT_WIDTH +: BIT_WIDTH] =
        rot_amt[s] ? stg[s][SRC*BIT_WIDTH +: BIT_WIDTH]
                   : stg[s][i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  assign vec_out = stg[AW];

endmodule

// File: rtl/gsim_rot_shreg.sv
// ---------------------------------------------------------------------------
// gsim_rot_shreg
// Circular vector register for the Gauss-Seidel solver. Loaded serially in
// FILL, then rotated by a per-operation amount in RUN with optional
// write-back into the last entry. Entry 0 is the unknown being updated; its
// +/-1..NTAP circular neighbours are exposed as taps.
// Optional: define GSIM_SHREG_CLR_EN to add the clr input, which zeroes all
// entries in addition to the restart actions (clr > restart > load/op/write).
// Ports:
//   clk, rst_n        clock (rising), asynchronous active-low reset
//   restart           back to FILL; clear fill count, pos, iter_cnt
//   clr               (GSIM_SHREG_CLR_EN only) restart plus zero entries
//   in_valid/in_ready/in_data   serial load handshake (FILL)
//   op_valid/op_ready/rot_amt   rotate request (RUN)
//   wr_en/wr_data     write entry DEPTH-1 after any rotation (RUN)
//   center            entry 0
//   tap_hi / tap_lo   slice k-1 = entry k / entry DEPTH-k, k=1..NTAP
//   full              state is RUN
//   pos               accumulated rotation mod DEPTH
//   wrap              one-cycle pulse when pos wraps past DEPTH
//   iter_cnt          completed sweeps, saturating
// ---------------------------------------------------------------------------
module gsim_rot_shreg
  import gsim_pkg::*;
#(
  parameter  int BIT_WIDTH = GSIM_BIT_WIDTH,
  parameter  int DEPTH     = GSIM_DEPTH,
  parameter  int NTAP      = GSIM_NTAP,
  parameter  int ITER_W    = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      restart,
`ifdef GSIM_SHREG_CLR_EN
  input  logic                      clr,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIT_WIDTH-1:0]      in_data,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [AW-1:0]             rot_amt,
  input  logic                      wr_en,
  input  logic [BIT_WIDTH-1:0]      wr_data,
  output logic [BIT_WIDTH-1:0]      center,
  output logic [NTAP*BIT_WIDTH-1:0] tap_hi,
  output logic [NTAP*BIT_WIDTH-1:0] tap_lo,
  output logic                      full,
  output logic [AW-1:0]             pos,
  output logic                      wrap,
  output logic [ITER_W-1:0]         iter_cnt
);

  localparam int VW = DEPTH * BIT_WIDTH;

  logic [VW-1:0]     ent_q, ent_d, rot_vec;
  gsim_state_e       state_q, state_d;
  logic [AW-1:0]     fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]     pos_q, pos_d;
  logic              wrap_q, wrap_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [AW:0]       pos_sum;
  logic              clr_req;

`ifdef GSIM_SHREG_CLR_EN
  assign clr_req = clr;
`else
  assign clr_req = 1'b0;
`endif

  gsim_rot_net #(
    .BIT_WIDTH(BIT_WIDTH),
    .DEPTH    (DEPTH)
  ) u_rot (
    .vec_in (ent_q),
    .rot_amt(rot_amt),
    .vec_out(rot_vec)
  );

  // Carry out of the AW+1 bit sum marks a wrap past entry 0 (a finished sweep).
  assign pos_sum = {1'b0, pos_q} + {1'b0, rot_amt};

  always_comb begin
    ent_d      = ent_q;
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    pos_d      = pos_q;
    wrap_d     = 1'b0;
    iter_d     = iter_q;
    if (clr_req || restart) begin
      if (clr_req) begin
        ent_d = '0;
      end
      state_d    = FILL;
      fill_cnt_d = '0;
      pos_d      = '0;
      iter_d     = '0;
    end else if (state_q == FILL) begin
      if (in_valid) begin
        // Shift toward entry 0; after DEPTH loads the first word sits at 0.
        ent_d      = {in_data, ent_q[VW-1:BIT_WIDTH]};
        fill_cnt_d = fill_cnt_q + AW'(1);
        if (fill_cnt_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
    end else begin
      if (op_valid) begin
        ent_d = rot_vec;
        pos_d = pos_sum[AW-1:0];
        if (pos_sum[AW]) begin
          wrap_d = 1'b1;
          if (iter_q != '1) begin
            iter_d = iter_q + ITER_W'(1);
          end
        end
      end
      // Write-back lands after the rotation and overrides the rotated word.
      if (wr_en) begin
        ent_d[VW-1 -: BIT_WIDTH] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q      <= '0;
      state_q    <= FILL;
      fill_cnt_q <= '0;
      pos_q      <= '0;
      wrap_q     <= 1'b0;
      iter_q     <= '0;
    end else begin
      ent_q      <= ent_d;
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      pos_q      <= pos_d;
      wrap_q     <= wrap_d;
      iter_q     <= iter_d;
    end
  end

  assign center = ent_q[BIT_WIDTH-1:0];

  for (genvar k = 1; k <= NTAP; k++) begin : g_tap
    assign tap_hi[(k-1)*BIT_WIDTH +: BIT_WIDTH] = ent_q[k*BIT_WIDTH +: BIT_WIDTH];
    assign tap_lo[(k-1)*BIT_WIDTH +: BIT_WIDTH] = ent_q[(DEPTH-k)*BIT_WIDTH +: BIT_WIDTH];
  end

  assign full     = (state_q == RUN);
  assign in_ready = (state_q == FILL);
  assign op_ready = (state_q == RUN);
  assign pos      = pos_q;
  assign wrap     = wrap_q;
  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_gsim_rot_shreg.sv
// ---------------------------------------------------------------------------
// tb_gsim_rot_shreg
// Two instances share all inputs: u_dut (ITER_W=8) and u_dut2 (ITER_W=2, for
// sweep-counter saturation). A behavioural array model predicts every output.
// Define GSIM_SHREG_CLR_EN to exercise the clr input.
// ---------------------------------------------------------------------------
module tb_gsim_rot_shreg;

  localparam int D  = 16;
  localparam int NT = 3;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          op_valid = 1'b0;
  logic [3:0]    rot_amt = '0;
  logic          wr_en = 1'b0;
  logic [BW-1:0] wr_data = '0;

  logic             in_ready, op_ready, full, wrap;
  logic [BW-1:0]    center;
  logic [NT*BW-1:0] tap_hi, tap_lo;
  logic [3:0]       pos;
  logic [7:0]       iter_cnt;

  logic             in_ready2, op_ready2, full2, wrap2;
  logic [BW-1:0]    center2;
  logic [NT*BW-1:0] tap_hi2, tap_lo2;
  logic [3:0]       pos2;
  logic [1:0]       iter_cnt2;

  always #5 clk = ~clk;

  gsim_rot_shreg #(.BIT_WIDTH(BW), .DEPTH(D), .NTAP(NT), .ITER_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
`ifdef GSIM_SHREG_CLR_EN
    .clr(clr),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .op_valid(op_valid), .op_ready(op_ready), .rot_amt(rot_amt),
    .wr_en(wr_en), .wr_data(wr_data),
    .center(center), .tap_hi(tap_hi), .tap_lo(tap_lo),
    .full(full), .pos(pos), .wrap(wrap), .iter_cnt(iter_cnt)
  );

  gsim_rot_shreg #(.BIT_WIDTH(BW), .DEPTH(D), .NTAP(NT), .ITER_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .restart(restart),
`ifdef GSIM_SHREG_CLR_EN
    .clr(clr),
`endif
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .op_valid(op_valid), .op_ready(op_ready2), .rot_amt(rot_amt),
    .wr_en(wr_en), .wr_data(wr_data),
    .center(center2), .tap_hi(tap_hi2), .tap_lo(tap_lo2),
    .full(full2), .pos(pos2), .wrap(wrap2), .iter_cnt(iter_cnt2)
  );

  // Behavioural model state.
  logic [BW-1:0] m_ent [D];
  bit            m_full, m_wrap;
  int            m_fill, m_pos, m_iter8, m_iter2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_ent[i] = '0;
    m_full = 0; m_wrap = 0; m_fill = 0; m_pos = 0; m_iter8 = 0; m_iter2 = 0;
  endtask

  // Applies the register's rules to the inputs present at this clock edge.
  task automatic model_step();
    logic [BW-1:0] tmp [D];
    m_wrap = 0;
    if (clr || restart) begin
      if (clr) for (int i = 0; i < D; i++) m_ent[i] = '0;
      m_full = 0; m_fill = 0; m_pos = 0; m_iter8 = 0; m_iter2 = 0;
    end else if (!m_full) begin
      if (in_valid) begin
        for (int i = 0; i < D - 1; i++) m_ent[i] = m_ent[i+1];
        m_ent[D-1] = in_data;
        m_fill++;
        if (m_fill == D) begin
          m_full = 1;
          m_fill = 0;
        end
      end
    end else begin
      if (op_valid) begin
        for (int i = 0; i < D; i++) tmp[i] = m_ent[(i + int'(rot_amt)) % D];
        m_ent = tmp;
        if (m_pos + int'(rot_amt) >= D) begin
          m_wrap = 1;
          if (m_iter8 < 255) m_iter8++;
          if (m_iter2 < 3) m_iter2++;
        end
        m_pos = (m_pos + int'(rot_amt)) % D;
      end
      if (wr_en) m_ent[D-1] = wr_data;
    end
  endtask

  task automatic compare_all();
    check_val("center", center, m_ent[0]);
    check_val("center2", center2, m_ent[0]);
    for (int k = 1; k <= NT; k++) begin
      check_val($sformatf("tap_hi%0d", k), tap_hi[(k-1)*BW +: BW], m_ent[k]);
      check_val($sformatf("tap_lo%0d", k), tap_lo[(k-1)*BW +: BW], m_ent[D-k]);
      check_val($sformatf("tap_hi2_%0d", k), tap_hi2[(k-1)*BW +: BW], m_ent[k]);
      check_val($sformatf("tap_lo2_%0d", k), tap_lo2[(k-1)*BW +: BW], m_ent[D-k]);
    end
    check_val("full", 32'(full), 32'(m_full));
    check_val("full2", 32'(full2), 32'(m_full));
    check_val("in_ready", 32'(in_ready), 32'(!m_full));
    check_val("in_ready2", 32'(in_ready2), 32'(!m_full));
    check_val("op_ready", 32'(op_ready), 32'(m_full));
    check_val("op_ready2", 32'(op_ready2), 32'(m_full));
    check_val("pos", 32'(pos), 32'(m_pos));
    check_val("pos2", 32'(pos2), 32'(m_pos));
    check_val("wrap", 32'(wrap), 32'(m_wrap));
    check_val("wrap2", 32'(wrap2), 32'(m_wrap));
    check_val("iter_cnt", 32'(iter_cnt), 32'(m_iter8));
    check_val("iter_cnt2", 32'(iter_cnt2), 32'(m_iter2));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    restart = 0; clr = 0; in_valid = 0; op_valid = 0; wr_en = 0;
    rot_amt = '0; in_data = '0; wr_data = '0;
  endtask

  task automatic load_words(input int n, input bit seq, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_data  = seq ? 32'(base + i) : $urandom;
      step();
    end
    idle();
  endtask

  task automatic do_op(input int amt, input bit we, input logic [BW-1:0] wd);
    op_valid = 1; rot_amt = 4'(amt); wr_en = we; wr_data = wd;
    step();
    idle();
  endtask

  int wc;

  initial begin
    model_reset();
    idle();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check_val("rst_full", 32'(full), 32'd0);
    rst_n = 1;

    // Sequential load 1..16
    load_words(D, 1, 1);
    check_val("load_full", 32'(full), 32'd1);
    check_val("load_center", center, 32'd1);
    check_val("load_hi0", tap_hi[0 +: BW], 32'd2);
    check_val("load_hi2", tap_hi[2*BW +: BW], 32'd4);
    check_val("load_lo0", tap_lo[0 +: BW], 32'd16);
    check_val("load_lo2", tap_lo[2*BW +: BW], 32'd14);
    // 17th load is ignored in RUN
    in_valid = 1; in_data = 32'd99; step(); idle();
    check_val("load17_center", center, 32'd1);

    // Sixteen rotations by one: one full sweep
    wc = 0;
    for (int j = 1; j <= D; j++) begin
      do_op(1, 0, '0);
      check_val("sweep_center", center, 32'((j % D) + 1));
      if (wrap) wc++;
    end
    check_val("sweep_wraps", 32'(wc), 32'd1);
    check_val("sweep_pos", 32'(pos), 32'd0);
    check_val("sweep_iter", 32'(iter_cnt), 32'd1);

    // Rotate 5 then 12
    do_op(5, 0, '0);
    check_val("rot5_pos", 32'(pos), 32'd5);
    check_val("rot5_center", center, 32'd6);
    do_op(12, 0, '0);
    check_val("rot12_pos", 32'(pos), 32'd1);
    check_val("rot12_wrap", 32'(wrap), 32'd1);
    check_val("rot12_center", center, 32'd2);

    // Rotation with write-back, then write in place, then no-op rotation
    do_op(4, 1, 32'hAAAA_AAAA);
    check_val("wb_lo0", tap_lo[0 +: BW], 32'hAAAA_AAAA);
    wr_en = 1; wr_data = 32'h1234_5678; step(); idle();
    check_val("wip_lo0", tap_lo[0 +: BW], 32'h1234_5678);
    do_op(0, 0, '0);

    // Restart mid-fill drops the same-cycle load
    restart = 1; step(); idle();
    load_words(7, 0, 0);
    restart = 1; in_valid = 1; in_data = 32'hDEAD_BEEF; step(); idle();
    load_words(D - 1, 0, 0);
    check_val("refill15_full", 32'(full), 32'd0);
    load_words(1, 0, 0);
    check_val("refill16_full", 32'(full), 32'd1);

    // Four sweeps of rot 8: 2-bit counter saturates
    wc = 0;
    for (int j = 0; j < 8; j++) begin
      do_op(8, 0, '0);
      if (wrap2) wc++;
    end
    check_val("sat_wraps", 32'(wc), 32'd4);
    check_val("sat_iter2", 32'(iter_cnt2), 32'd3);
    check_val("sat_iter8", 32'(iter_cnt), 32'd4);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      op_valid = ($urandom_range(0, 3) != 0);
      rot_amt  = 4'($urandom_range(0, 15));
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_data  = $urandom;
      restart  = ($urandom_range(0, 39) == 0);
`ifdef GSIM_SHREG_CLR_EN
      clr      = ($urandom_range(0, 59) == 0);
`endif
      step();
    end
    idle();

    // Asynchronous reset between edges
    #2 rst_n = 0;
    #1;
    model_reset();
    compare_all();
    #1 rst_n = 1;

`ifdef GSIM_SHREG_CLR_EN
    load_words(D, 0, 0);
    do_op(3, 0, '0);
    clr = 1; restart = 1; in_valid = 1; step(); idle();
    check_val("clr_center", center, 32'd0);
    check_val("clr_hi0", tap_hi[0 +: BW], 32'd0);
    check_val("clr_lo0", tap_lo[0 +: BW], 32'd0);
    check_val("clr_full", 32'(full), 32'd0);
    check_val("clr_pos", 32'(pos), 32'd0);
    check_val("clr_iter", 32'(iter_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
